// File: rtl/sudoku_puzzle_feeder.sv
// Host-side puzzle source and answer sink for the sudoku solver core:
// nibble-stream loader into an input FIFO, result FIFO with nibble-stream unload.
module sudoku_puzzle_feeder #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         flush,
  input  logic         ld_valid,
  input  logic [3:0]   ld_nib,
  output logic         ld_ready,
  output logic         rd_valid,
  output logic [3:0]   rd_nib,
  output logic         rd_last,
  input  logic         rd_ready,
  output logic         go,
  output logic         puzzle_avail,
  output logic [323:0] puzzle_in,
  input  logic         read_puzzle,
  input  logic         done_puzzle,
  input  logic [323:0] puzzle_out,
  output logic         underrun,
  output logic         overrun,
  output logic [15:0]  done_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [6:0]    LAST_CELL = 7'd80;

  logic [323:0]  ld_shift;
  logic [323:0]  ld_word;
  logic [6:0]    ld_idx;
  logic [8:0]    ld_sh;
  logic          ld_fire;

  logic [323:0]  in_mem [DEPTH];
  logic [AW-1:0] in_wr;
  logic [AW-1:0] in_rd;
  logic [CW-1:0] in_count;
  logic          in_push;
  logic          in_pop;

  logic [323:0]  res_mem [DEPTH];
  logic [AW-1:0] res_wr;
  logic [AW-1:0] res_rd;
  logic [CW-1:0] res_count;
  logic          res_push;
  logic          res_pop;
  logic [323:0]  res_head;
  logic [323:0]  rd_shifted;
  logic [6:0]    rd_idx;
  logic [8:0]    rd_sh;

  logic          run;

  // Cell k lives at bit offset 4*(80-k); insert/extract by shifting a nibble mask.
  always_comb begin
    ld_ready   = (in_count != FULL);
    ld_fire    = ld_valid && ld_ready;
    ld_sh      = 9'(LAST_CELL - ld_idx) << 2;
    ld_word    = (ld_shift & ~({320'd0, 4'hF} << ld_sh)) | ({320'd0, ld_nib} << ld_sh);
    in_push    = ld_fire && (ld_idx == LAST_CELL);
    in_pop     = read_puzzle && (in_count != '0);
    puzzle_in  = (in_count != '0) ? in_mem[in_rd] : '0;

    puzzle_avail = ((in_count != '0) || flush) && (res_count != FULL);

    rd_valid   = (res_count != '0);
    res_head   = res_mem[res_rd];
    rd_sh      = 9'(LAST_CELL - rd_idx) << 2;
    rd_shifted = res_head >> rd_sh;
    rd_nib     = rd_valid ? rd_shifted[3:0] : '0;
    rd_last    = rd_valid && (rd_idx == LAST_CELL);
    res_pop    = rd_valid && rd_ready && rd_last;
    res_push   = done_puzzle && (res_count != FULL);

    go = run;
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= ld_word;
    if (res_push) res_mem[res_wr] <= puzzle_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_shift  <= '0;
      ld_idx    <= '0;
      in_wr     <= '0;
      in_rd     <= '0;
      in_count  <= '0;
      res_wr    <= '0;
      res_rd    <= '0;
      res_count <= '0;
      rd_idx    <= '0;
      run       <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (ld_fire) begin
        ld_shift <= ld_word;
        ld_idx   <= (ld_idx == LAST_CELL) ? '0 : ld_idx + 7'd1;
      end

      if (in_push) in_wr <= in_wr + AW'(1);
      if (in_pop)  in_rd <= in_rd + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + CW'(1);
        2'b01:   in_count <= in_count - CW'(1);
        default: in_count <= in_count;
      endcase
      if (read_puzzle && (in_count == '0)) underrun <= 1'b1;

      if (res_push) begin
        res_wr   <= res_wr + AW'(1);
        done_cnt <= done_cnt + 16'd1;
      end
      if (done_puzzle && (res_count == FULL)) overrun <= 1'b1;
      if (res_pop) res_rd <= res_rd + AW'(1);
      case ({res_push, res_pop})
        2'b10:   res_count <= res_count + CW'(1);
        2'b01:   res_count <= res_count - CW'(1);
        default: res_count <= res_count;
      endcase

      if (rd_valid && rd_ready)
        rd_idx <= rd_last ? '0 : rd_idx + 7'd1;

      if (stop)       run <= 1'b0;
      else if (start) run <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sudoku_puzzle_feeder.sv
// Directed bench for sudoku_puzzle_feeder: load path, input FIFO, underrun,
// result capture/unload, simultaneous push/pop and result back-pressure.
module tb_sudoku_puzzle_feeder;

  logic         clk = 1'b0;
  logic         rst, start, stop, flush, ld_valid, rd_ready;
  logic         read_puzzle, done_puzzle;
  logic [3:0]   ld_nib;
  logic [323:0] puzzle_out;
  logic         ld_ready, rd_valid, rd_last, go, puzzle_avail, underrun, overrun;
  logic [3:0]   rd_nib;
  logic [323:0] puzzle_in;
  logic [15:0]  done_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sudoku_puzzle_feeder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .flush(flush),
    .ld_valid(ld_valid), .ld_nib(ld_nib), .ld_ready(ld_ready),
    .rd_valid(rd_valid), .rd_nib(rd_nib), .rd_last(rd_last), .rd_ready(rd_ready),
    .go(go), .puzzle_avail(puzzle_avail), .puzzle_in(puzzle_in),
    .read_puzzle(read_puzzle), .done_puzzle(done_puzzle), .puzzle_out(puzzle_out),
    .underrun(underrun), .overrun(overrun), .done_cnt(done_cnt)
  );

  // Cell value pattern: seed 0 gives 1,2,...,9,1,2,... (the 0x123..9 answer).
  function automatic logic [3:0] pat(input int s, input int i);
    return 4'(((s + i) % 9) + 1);
  endfunction

  function automatic logic [323:0] mkword(input int s);
    logic [323:0] w;
    w = '0;
    for (int i = 0; i < 81; i++) w = {w[319:0], pat(s, i)};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [323:0] obs, input logic [323:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_puzzle(input int s);
    for (int i = 0; i < 81; i++) begin
      ld_valid = 1'b1;
      ld_nib   = pat(s, i);
      tick();
    end
    ld_valid = 1'b0;
    ld_nib   = '0;
  endtask

  task automatic pop_check(input string tag, input logic [323:0] exp);
    chk(tag, puzzle_in, exp);
    read_puzzle = 1'b1;
    tick();
    read_puzzle = 1'b0;
  endtask

  task automatic unload_check(input string tag, input logic [323:0] w, input int n);
    logic [323:0] t;
    t = w;
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_nib"}, 324'(rd_nib), 324'(t[323:320]));
      chk({tag, "_last"}, 324'(rd_last), 324'(i == 80));
      t = t << 4;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [323:0] wa;
    rst = 1'b1; start = 1'b0; stop = 1'b0; flush = 1'b0;
    ld_valid = 1'b0; ld_nib = '0; rd_ready = 1'b0;
    read_puzzle = 1'b0; done_puzzle = 1'b0; puzzle_out = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ld_ready", 324'(ld_ready), 324'(1));
    chk("rst_rd_valid", 324'(rd_valid), 324'(0));
    chk("rst_rd_nib", 324'(rd_nib), 324'(0));
    chk("rst_rd_last", 324'(rd_last), 324'(0));
    chk("rst_avail", 324'(puzzle_avail), 324'(0));
    chk("rst_go", 324'(go), 324'(0));
    chk("rst_puzzle_in", puzzle_in, '0);
    chk("rst_done_cnt", 324'(done_cnt), 324'(0));
    chk("rst_flags", 324'({underrun, overrun}), 324'(0));

    // Single load: cell 0 = 5, cell 80 = 4 for seed 4
    load_puzzle(4);
    wa = puzzle_in;
    chk("load_cell0", 324'(wa[323:320]), 324'(5));
    chk("load_cell80", 324'(wa[3:0]), 324'(4));
    chk("load_word", puzzle_in, mkword(4));
    chk("load_avail", 324'(puzzle_avail), 324'(1));
    chk("load_go_idle", 324'(go), 324'(0));

    // Fill the input FIFO, pop one, refill, then drain in order
    load_puzzle(1);
    load_puzzle(2);
    chk("part_ld_ready", 324'(ld_ready), 324'(1));
    load_puzzle(3);
    chk("full_ld_ready", 324'(ld_ready), 324'(0));
    pop_check("pop_head0", mkword(4));
    chk("after_pop_ld_ready", 324'(ld_ready), 324'(1));
    chk("after_pop_head", puzzle_in, mkword(1));
    load_puzzle(7);
    chk("refull_ld_ready", 324'(ld_ready), 324'(0));
    pop_check("pop_head1", mkword(1));
    pop_check("pop_head2", mkword(2));
    pop_check("pop_head3", mkword(3));
    pop_check("pop_head4", mkword(7));
    chk("drained_puzzle_in", puzzle_in, '0);
    chk("drained_avail", 324'(puzzle_avail), 324'(0));
    chk("drained_underrun", 324'(underrun), 324'(0));

    // Run control
    start = 1'b1; tick(); start = 1'b0;
    chk("go_after_start", 324'(go), 324'(1));
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("go_stop_wins", 324'(go), 324'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("go_restart", 324'(go), 324'(1));

    // Core-driven underrun on an empty input FIFO
    read_puzzle = 1'b1;
    chk("underrun_puzzle_in", puzzle_in, '0);
    tick();
    tick();
    read_puzzle = 1'b0;
    chk("underrun_flag", 324'(underrun), 324'(1));
    chk("underrun_avail", 324'(puzzle_avail), 324'(0));
    chk("underrun_ld_ready", 324'(ld_ready), 324'(1));
    chk("underrun_puzzle_in2", puzzle_in, '0);

    // Result capture and full unload
    puzzle_out = mkword(0); done_puzzle = 1'b1; tick(); done_puzzle = 1'b0;
    chk("cap_done_cnt", 324'(done_cnt), 324'(1));
    chk("cap_rd_valid", 324'(rd_valid), 324'(1));
    unload_check("unload_p", mkword(0), 81);
    chk("unload_empty", 324'(rd_valid), 324'(0));
    chk("unload_nib_zero", 324'(rd_nib), 324'(0));

    // done_puzzle coincides with the final unload handshake
    puzzle_out = mkword(3); done_puzzle = 1'b1; tick(); done_puzzle = 1'b0;
    unload_check("unload_b", mkword(3), 80);
    chk("sim_rd_last", 324'(rd_last), 324'(1));
    chk("sim_nib80", 324'(rd_nib), 324'(pat(3, 80)));
    rd_ready = 1'b1; puzzle_out = mkword(8); done_puzzle = 1'b1;
    tick();
    rd_ready = 1'b0; done_puzzle = 1'b0;
    chk("sim_rd_valid", 324'(rd_valid), 324'(1));
    chk("sim_new_head", 324'(rd_nib), 324'(pat(8, 0)));
    chk("sim_done_cnt", 324'(done_cnt), 324'(3));

    // Fill the result FIFO: one entry held, three more make it full
    flush = 1'b1;
    tick();
    chk("flush_avail", 324'(puzzle_avail), 324'(1));
    puzzle_out = mkword(5); done_puzzle = 1'b1; tick();
    puzzle_out = mkword(6); tick(); done_puzzle = 1'b0;
    chk("res3_avail", 324'(puzzle_avail), 324'(1));
    puzzle_out = mkword(2); done_puzzle = 1'b1; tick(); done_puzzle = 1'b0;
    chk("res_full_avail", 324'(puzzle_avail), 324'(0));
    chk("res_full_done_cnt", 324'(done_cnt), 324'(6));
    chk("pre_overrun", 324'(overrun), 324'(0));
    puzzle_out = mkword(1); done_puzzle = 1'b1; tick(); done_puzzle = 1'b0;
    chk("overrun_flag", 324'(overrun), 324'(1));
    chk("overrun_done_cnt", 324'(done_cnt), 324'(6));

    unload_check("unload_c", mkword(8), 81);
    chk("next_head_d", 324'(rd_nib), 324'(pat(5, 0)));
    chk("reopen_avail", 324'(puzzle_avail), 324'(1));
    chk("sticky_flags", 324'({underrun, overrun}), 324'(3));

    // Reset discards stored answers and clears sticky flags
    rst = 1'b1; tick(); rst = 1'b0; flush = 1'b0; tick();
    chk("rst2_rd_valid", 324'(rd_valid), 324'(0));
    chk("rst2_flags", 324'({underrun, overrun}), 324'(0));
    chk("rst2_done_cnt", 324'(done_cnt), 324'(0));
    chk("rst2_go", 324'(go), 324'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sudoku_puzzle_feeder.md
# sudoku_puzzle_feeder

Host-facing puzzle source and answer sink for the sudoku solver core. It assembles puzzles from a 4-bit host load stream into an input FIFO and presents the FIFO head on the core's puzzle bus. It drives the core's availability and go inputs, captures every finished answer into a result FIFO, and streams answers back to the host one nibble at a time. It sits between the host/test wrapper and the solver core, on the far side of the core's puzzle_avail / read_puzzle / done_puzzle handshake.

## Interface
- DEPTH, 4: entries in the input FIFO and in the result FIFO; power of two, at least 2.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; sets run.
- stop  in  1  pulse; clears run. stop wins if asserted in the same cycle as start.
- flush  in  1  level; lets the core drain with all-zero puzzles when the input FIFO is empty.
- ld_valid  in  1  host load nibble valid.
- ld_nib  in  4  host load nibble; cell order row 0 col 0 first, row 8 col 8 last.
- ld_ready  out  1  high when the input FIFO is not full.
- rd_valid  out  1  high when the result FIFO is not empty.
- rd_nib  out  4  current nibble of the head answer.
- rd_last  out  1  rd_nib is cell 80.
- rd_ready  in  1  host accepts rd_nib.
- go  out  1  core go; equals the run register.
- puzzle_avail  out  1  to core.
- puzzle_in  out  324  to core; head of the input FIFO, or 0 when the FIFO is empty.
- read_puzzle  in  1  from core; pops the input FIFO.
- done_puzzle  in  1  from core; pushes puzzle_out into the result FIFO.
- puzzle_out  in  324  from core.
- underrun  out  1  sticky: read_puzzle arrived while the input FIFO was empty.
- overrun  out  1  sticky: done_puzzle arrived while the result FIFO was full.
- done_cnt  out  16  number of answers captured; wraps at 16 bits.

## Operation
- **Load assembler**
  - Shift register, 324 bits, plus a 7-bit cell counter ld_idx (0..80).
  - On each ld_valid && ld_ready: the nibble goes into bits [323-4*ld_idx -: 4].
  - At ld_idx == 80 the completed word (including the current nibble) is pushed into the input FIFO in the same cycle, and ld_idx returns to 0.
  - ld_ready = (in_count != DEPTH). Because of this, the 81st nibble is never blocked from pushing.
- **Input FIFO**
  - Holds DEPTH × 324 bits, with a count of width log2(DEPTH)+1.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop when empty does not move the pointers; it sets underrun. This case is legal during core priming, which reads regardless of puzzle_avail.
- **puzzle_avail** = (in_count != 0 || flush) && (res_count != DEPTH). The core only asserts done_puzzle while puzzle_avail is high, so a result slot always exists under correct use.
- **Result FIFO**
  - DEPTH × 324 bits. On done_puzzle, puzzle_out is pushed and done_cnt increments.
  - If the FIFO is full, the push is dropped, overrun is set, and done_cnt does not increment.
- **Unload**
  - rd_idx (0..80) selects rd_nib = head[323-4*rd_idx -: 4].
  - On rd_valid && rd_ready: rd_idx increments. When rd_last is high, the head is popped and rd_idx returns to 0.
  - A result pop and a done_puzzle push in the same cycle are both honoured.
- **Run control**: run is set by start and cleared by stop. While run is low, go is low; loading and unloading continue.
- **Reset values**
  - All pointers, counts, ld_idx, rd_idx, run, underrun, overrun and done_cnt = 0.
  - Outputs: ld_ready = 1, rd_valid = 0, rd_nib = 0, rd_last = 0, go = 0, puzzle_avail = 0, puzzle_in = 0.
  - Reset mid-load discards the partial puzzle. Reset mid-unload discards all stored answers.
  - underrun and overrun clear only on reset.

## Timing
- All state updates on the rising clk edge; all outputs are combinational from registers or FIFO heads.
- Load latency: the 81st handshake in cycle N makes puzzle_in valid and in_count incremented in cycle N+1.
- The core samples puzzle_in in the same cycle it asserts read_puzzle. puzzle_in shows the next entry from the cycle after the pop.
- done_puzzle in cycle N gives rd_valid high from cycle N+1 if the result FIFO was empty.
- go follows start/stop one cycle later.
- Throughput:
  - one load nibble per cycle;
  - one unload nibble per cycle;
  - one core pop plus one core push per cycle.

## Test plan
- **Reset and idle**: reset, then idle → ld_ready = 1, rd_valid = 0, puzzle_avail = 0, go = 0, puzzle_in = 0.
- **Single load**: load 81 nibbles of a known puzzle, e.g. cell 0 = 5 and cell 80 = 9 → next cycle puzzle_in[323:320] = 5, puzzle_in[3:0] = 9, puzzle_avail = 1.
- **Full input FIFO**: load DEPTH puzzles → ld_ready = 0. Pulse read_puzzle once → ld_ready = 1 the next cycle, and the next load lands in order.
- **Core-driven underrun**: start, then read_puzzle pulses with the input FIFO empty → puzzle_in = 0, underrun = 1, in_count stays 0.
- **Result capture and unload**: drive done_puzzle with puzzle_out = 0x123…9 pattern → done_cnt = 1. Hold rd_ready high → 81 nibbles in cell order, rd_last on the 81st, then rd_valid = 0.
- **Simultaneous events and back-pressure**:
  - done_puzzle in the same cycle as the final unload handshake → res_count unchanged and the new answer becomes head.
  - Fill the result FIFO → puzzle_avail = 0.
  - Force done_puzzle anyway → overrun = 1 and done_cnt unchanged.
